// File: rtl/imm_extend_pipe_if.sv
// Request/response bus for imm_extend_pipe.
//   Request side : in_valid, in_ready, in_imm, in_mode
//   Response side: out_valid, out_ready, out_data
//   Status       : count (buffer occupancy)
// master : the request producer / result consumer.
// slave  : the extender pipeline itself.
interface imm_extend_pipe_if #(
   parameter int IN_BITS  = 16,
   parameter int OUT_BITS = 32,
   parameter int DEPTH    = 2
);
   localparam int CW = $clog2(DEPTH + 1);

   logic                in_valid;
   logic                in_ready;
   logic [IN_BITS-1:0]  in_imm;
   logic [1:0]          in_mode;
   logic                out_valid;
   logic                out_ready;
   logic [OUT_BITS-1:0] out_data;
   logic [CW-1:0]       count;

   modport master (
      output in_valid, in_imm, in_mode, out_ready,
      input  in_ready, out_valid, out_data, count
   );

   modport slave (
      input  in_valid, in_imm, in_mode, out_ready,
      output in_ready, out_valid, out_data, count
   );
endinterface

// File: rtl/imm_extend_pipe.sv
// Immediate extender with a small output FIFO.
// Each accepted request is extended combinationally (sign, zero, upper or
// branch-offset form) and written into a circular buffer of DEPTH entries;
// results leave in order through a valid/ready handshake.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   flush : drops every buffered result (wins over same-edge push/pop)
//   bus   : slave side of imm_extend_pipe_if (request, response, count)
module imm_extend_pipe #(
   parameter int IN_BITS  = 16,
   parameter int OUT_BITS = 32,
   parameter int BR_SHIFT = 2,
   parameter int DEPTH    = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   imm_extend_pipe_if.slave  bus
);

   localparam int EXT = OUT_BITS - IN_BITS;
   localparam int CW  = $clog2(DEPTH + 1);
   localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {
      MODE_SIGN   = 2'd0,
      MODE_ZERO   = 2'd1,
      MODE_UPPER  = 2'd2,
      MODE_BRANCH = 2'd3
   } imm_mode_e;

   logic [OUT_BITS-1:0] mem [DEPTH];
   logic [PW-1:0]       wr_ptr, rd_ptr;
   logic [CW-1:0]       count_q;
   logic [OUT_BITS-1:0] sext, ext_res;
   logic                push, pop;

   function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   always_comb begin
      sext    = {{EXT{bus.in_imm[IN_BITS-1]}}, bus.in_imm};
      ext_res = '0;
      case (imm_mode_e'(bus.in_mode))
         MODE_SIGN:   ext_res = sext;
         MODE_ZERO:   ext_res = {{EXT{1'b0}}, bus.in_imm};
         MODE_UPPER:  ext_res = {bus.in_imm, {EXT{1'b0}}};
         MODE_BRANCH: ext_res = sext << BR_SHIFT;
         default:     ext_res = '0;
      endcase
   end

   // in_ready comes from occupancy only, never from out_ready, so a full
   // buffer cannot accept even on a popping edge.
   assign bus.in_ready  = (count_q < CW'(DEPTH)) && rst_n;
   assign bus.out_valid = (count_q != '0);
   // Storage is never cleared; masking with out_valid keeps the output at
   // zero after reset/flush instead of exposing stale entries.
   assign bus.out_data  = bus.out_valid ? mem[rd_ptr] : '0;
   assign bus.count     = count_q;

   assign push = bus.in_valid && bus.in_ready && !flush;
   assign pop  = bus.out_valid && bus.out_ready && !flush;

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= ext_res;
   end

   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         count_q <= '0;
         wr_ptr  <= '0;
         rd_ptr  <= '0;
      end else begin
         if (push) wr_ptr <= ptr_next(wr_ptr);
         if (pop)  rd_ptr <= ptr_next(rd_ptr);
         case ({push, pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed self-checking bench for imm_extend_pipe: default-parameter
// instance plus an 8->16 bit instance with BR_SHIFT=1.
module tb_imm_extend_pipe;

   logic clk = 1'b0;
   logic rst_n;
   logic flush;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   imm_extend_pipe_if #(.IN_BITS(16), .OUT_BITS(32), .DEPTH(2)) bus ();
   imm_extend_pipe_if #(.IN_BITS(8),  .OUT_BITS(16), .DEPTH(2)) bus8 ();

   imm_extend_pipe #(.IN_BITS(16), .OUT_BITS(32), .BR_SHIFT(2), .DEPTH(2)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus.slave)
   );

   imm_extend_pipe #(.IN_BITS(8), .OUT_BITS(16), .BR_SHIFT(1), .DEPTH(2)) dut8 (
      .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus8.slave)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Move to just after the next rising edge (input drive point).
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Sampling point, half a cycle away from the active edge.
   task automatic smp();
      @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n = 1'b0;
      flush = 1'b0;
      bus.in_valid   = 1'b0; bus.in_imm  = '0; bus.in_mode  = 2'd0; bus.out_ready  = 1'b1;
      bus8.in_valid  = 1'b0; bus8.in_imm = '0; bus8.in_mode = 2'd0; bus8.out_ready = 1'b1;

      // Reset state
      step(); step();
      smp();
      chk("rst_count",     64'(bus.count),     64'd0);
      chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_in_ready",  64'(bus.in_ready),  64'd0);
      chk("rst_out_data",  64'(bus.out_data),  64'd0);
      step();
      rst_n = 1'b1;
      smp();
      chk("rel_in_ready", 64'(bus.in_ready), 64'd1);

      // Sign mode, one-cycle latency, single-cycle valid
      step();
      bus.in_valid = 1'b1; bus.in_imm = 16'h8001; bus.in_mode = 2'd0;
      step();
      bus.in_valid = 1'b0;
      smp();
      chk("sign_valid", 64'(bus.out_valid), 64'd1);
      chk("sign_data",  64'(bus.out_data),  64'hFFFF8001);
      step();
      smp();
      chk("sign_valid_drop", 64'(bus.out_valid), 64'd0);

      // Zero / upper / branch streamed back to back
      bus.in_valid = 1'b1; bus.in_imm = 16'hFFFE; bus.in_mode = 2'd1;
      step();
      bus.in_mode = 2'd2;
      smp();
      chk("zero_data", 64'(bus.out_data), 64'h0000FFFE);
      step();
      bus.in_mode = 2'd3;
      smp();
      chk("upper_data", 64'(bus.out_data), 64'hFFFE0000);
      step();
      bus.in_valid = 1'b0;
      smp();
      chk("branch_data", 64'(bus.out_data), 64'hFFFFFFF8);
      chk("stream_count", 64'(bus.count), 64'd1);
      step();

      // Fill with out_ready low, third request refused
      bus.out_ready = 1'b0;
      bus.in_valid = 1'b1; bus.in_mode = 2'd1; bus.in_imm = 16'h0001;
      step();
      bus.in_imm = 16'h0002;
      step();
      bus.in_imm = 16'h0003;
      smp();
      chk("full_count",    64'(bus.count),    64'd2);
      chk("full_in_ready", 64'(bus.in_ready), 64'd0);
      step();
      bus.in_valid = 1'b0;
      smp();
      chk("full_hold_count", 64'(bus.count),    64'd2);
      chk("full_hold_data",  64'(bus.out_data), 64'h00000001);
      bus.out_ready = 1'b1;
      #1;
      chk("full_ready_indep", 64'(bus.in_ready), 64'd0);
      step();
      smp();
      chk("drain1_data",     64'(bus.out_data), 64'h00000002);
      chk("drain1_in_ready", 64'(bus.in_ready), 64'd1);
      chk("drain1_count",    64'(bus.count),    64'd1);
      step();
      smp();
      chk("drain2_count", 64'(bus.count),     64'd0);
      chk("drain2_valid", 64'(bus.out_valid), 64'd0);

      // Simultaneous push and pop at count=1
      bus.out_ready = 1'b0;
      bus.in_valid = 1'b1; bus.in_mode = 2'd1; bus.in_imm = 16'h0010;
      step();
      bus.out_ready = 1'b1; bus.in_imm = 16'h0020;
      step();
      bus.in_valid = 1'b0; bus.out_ready = 1'b0;
      smp();
      chk("pp_count", 64'(bus.count),    64'd1);
      chk("pp_data",  64'(bus.out_data), 64'h00000020);

      // Flush beats a same-edge push at count=1
      bus.in_valid = 1'b1; bus.in_imm = 16'h0030; flush = 1'b1;
      step();
      flush = 1'b0; bus.in_valid = 1'b0;
      smp();
      chk("flush1_count", 64'(bus.count), 64'd0);

      // Flush at count=2 with request and pop asserted
      bus.in_valid = 1'b1; bus.in_imm = 16'h0100;
      step();
      bus.in_imm = 16'h0200;
      step();
      bus.in_valid = 1'b0;
      smp();
      chk("pre_flush_count", 64'(bus.count), 64'd2);
      flush = 1'b1; bus.in_valid = 1'b1; bus.in_imm = 16'h0300; bus.out_ready = 1'b1;
      step();
      flush = 1'b0; bus.in_valid = 1'b0;
      smp();
      chk("flush2_count", 64'(bus.count),     64'd0);
      chk("flush2_valid", 64'(bus.out_valid), 64'd0);
      chk("flush2_data",  64'(bus.out_data),  64'd0);
      step();
      smp();
      chk("flush2_nocapture", 64'(bus.count), 64'd0);

      // Reset mid-operation at count=2
      bus.out_ready = 1'b0;
      bus.in_valid = 1'b1; bus.in_mode = 2'd0; bus.in_imm = 16'h1234;
      step();
      bus.in_imm = 16'h5678;
      step();
      bus.in_valid = 1'b0;
      smp();
      chk("pre_rst_count", 64'(bus.count), 64'd2);
      rst_n = 1'b0;
      step();
      smp();
      chk("mid_rst_count",    64'(bus.count),     64'd0);
      chk("mid_rst_valid",    64'(bus.out_valid), 64'd0);
      chk("mid_rst_data",     64'(bus.out_data),  64'd0);
      chk("mid_rst_in_ready", 64'(bus.in_ready),  64'd0);
      rst_n = 1'b1;
      step();
      smp();
      chk("post_rst_in_ready", 64'(bus.in_ready),  64'd1);
      chk("post_rst_valid",    64'(bus.out_valid), 64'd0);

      // 8->16 bit instance, BR_SHIFT=1
      bus8.in_valid = 1'b1; bus8.in_imm = 8'h81; bus8.in_mode = 2'd0;
      step();
      bus8.in_mode = 2'd3;
      smp();
      chk("p8_sign_data", 64'(bus8.out_data), 64'hFF81);
      step();
      bus8.in_valid = 1'b0;
      smp();
      chk("p8_branch_data", 64'(bus8.out_data), 64'hFF02);
      step();
      smp();
      chk("p8_empty", 64'(bus8.out_valid), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/imm_extend_pipe.md
IMM_EXTEND_PIPE -- requirements
Module: imm_extend_pipe

Interface
REQ-001 SHALL have parameter IN_BITS, default 16, immediate field width.
REQ-002 SHALL have parameter OUT_BITS, default 32, result width; legal only when OUT_BITS > IN_BITS.
REQ-003 SHALL have parameter BR_SHIFT, default 2, left shift for branch-offset mode; legal only when BR_SHIFT <= OUT_BITS-IN_BITS.
REQ-004 SHALL have parameter DEPTH, default 2, output buffer entries; legal range 1..8.
REQ-005 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-006 SHALL have port rst_n  input  1  synchronous, active-low reset.
REQ-007 SHALL have port flush  input  1  discards all buffered results.
REQ-008 SHALL have port in_valid  input  1  request present.
REQ-009 SHALL have port in_ready  output  1  request accepted when high together with in_valid.
REQ-010 SHALL have port in_imm  input  IN_BITS  unextended immediate.
REQ-011 SHALL have port in_mode  input  2  extension mode.
REQ-012 SHALL have port out_valid  output  1  result at head of buffer.
REQ-013 SHALL have port out_ready  input  1  consumer takes result when high together with out_valid.
REQ-014 SHALL have port out_data  output  OUT_BITS  extended result at buffer head.
REQ-015 SHALL have port count  output  clog2(DEPTH+1)  current buffer occupancy.

Function
REQ-016 Mode 0 (SIGN) SHALL produce in_imm replicated-MSB-extended to OUT_BITS.
REQ-017 Mode 1 (ZERO) SHALL produce in_imm zero-extended to OUT_BITS.
REQ-018 Mode 2 (UPPER) SHALL produce in_imm placed at bits [OUT_BITS-1:OUT_BITS-IN_BITS], lower bits zero.
REQ-019 Mode 3 (BRANCH) SHALL produce the mode-0 result shifted left by BR_SHIFT, vacated low bits zero.
REQ-020 Result SHALL be computed combinationally from in_imm/in_mode at acceptance and written into the buffer tail that edge; no result depends on prior requests.
REQ-021 Push SHALL occur when in_valid && in_ready; pop SHALL occur when out_valid && out_ready.
REQ-022 Latency SHALL be one cycle: a request accepted at edge N is visible on out_data/out_valid after edge N, i.e., in cycle N+1, when the buffer was empty.
REQ-023 Buffer SHALL be FIFO-ordered, circular with read/write pointers wrapping from DEPTH-1 to 0.
REQ-024 in_ready SHALL equal (count < DEPTH) && rst_n; it SHALL NOT depend combinationally on out_ready.
REQ-025 out_valid SHALL equal (count != 0); out_data SHALL be the head entry and SHALL hold stable while out_valid && !out_ready.
REQ-026 Simultaneous push and pop with 0 < count < DEPTH SHALL leave count unchanged and advance both pointers.
REQ-027 When full, in_ready is low and no push occurs even if a pop occurs that edge; in_ready rises the cycle after the pop.
REQ-028 When empty, pop cannot occur; a push into an empty buffer SHALL set count to 1.
REQ-029 flush SHALL set count to 0 and both pointers to 0 at the edge; flush SHALL take priority over a same-edge push and pop (neither takes effect).
REQ-030 in_valid while in_ready is low SHALL be ignored with no state change.

Reset
REQ-031 With rst_n low at a rising edge, count, read and write pointers SHALL become 0; out_valid and in_ready SHALL be low.
REQ-032 Reset mid-operation SHALL discard all buffered entries; no pre-reset result SHALL appear after reset.
REQ-033 out_data SHALL be 0 after reset until the first push; buffer storage need not be cleared otherwise.
REQ-034 in_ready SHALL be low while rst_n is low and SHALL rise in the first cycle after rst_n is sampled high.

Verification
REQ-035 Defaults, mode 0, in_imm=16'h8001, out_ready=1 -> next cycle out_data=32'hFFFF8001, out_valid=1 for one cycle.
REQ-036 Modes 1/2/3 with in_imm=16'hFFFE -> out_data 32'h0000FFFE, 32'hFFFE0000, 32'hFFFFFFF8 in order.
REQ-037 out_ready=0, push 3 requests (DEPTH=2) -> count=2, in_ready low, third request not accepted; raise out_ready -> first two results popped in order, in_ready rises cycle after first pop.
REQ-038 count=1, push and pop same edge -> count stays 1, out_data shows second request.
REQ-039 count=2 with flush and in_valid asserted same edge -> count=0, out_valid=0, no entry captured.
REQ-040 rst_n low for one edge with count=2 -> count=0, out_valid=0, out_data=0, in_ready=0, then in_ready=1 in the first cycle after rst_n is sampled high; parameter sweep IN_BITS=8/OUT_BITS=16/BR_SHIFT=1 repeats REQ-035 with 8'h81 -> 16'hFF81.
